// File: rtl/cmplx_pkg.sv
// rtl/cmplx_pkg.sv - shared constants, state type and {re,im} unpack helpers for the complex datapath
package cmplx_pkg;

  localparam int PW_DEF    = 16;
  localparam int ACC_W_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic signed [PW_DEF-1:0] cmplx_re(input logic [2*PW_DEF-1:0] w);
    return w[2*PW_DEF-1:PW_DEF];
  endfunction

  function automatic logic signed [PW_DEF-1:0] cmplx_im(input logic [2*PW_DEF-1:0] w);
    return w[PW_DEF-1:0];
  endfunction

endpackage

// File: rtl/cmplx_sat_add.sv
// rtl/cmplx_sat_add.sv - signed saturating adder with saturation flag
module cmplx_sat_add #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat
);

  logic [W:0] wide;

  // One guard bit: the W-bit result overflowed exactly when the top two bits disagree
  always_comb begin
    wide = {a[W-1], a} + {b[W-1], b};
    sum  = wide[W-1:0];
    sat  = 1'b0;
    if (wide[W] != wide[W-1]) begin
      sat = 1'b1;
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/cmplx_prod_acc.sv
// rtl/cmplx_prod_acc.sv - per-frame saturating accumulator of complex products (complex dot product)
module cmplx_prod_acc
  import cmplx_pkg::*;
#(
  parameter  int PW        = PW_DEF,
  parameter  int ACC_W     = ACC_W_DEF,
  parameter  int MAX_TERMS = 16,
  localparam int CNT_W     = $clog2(MAX_TERMS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*PW-1:0]    in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*ACC_W-1:0] out_data,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_ovf
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

  state_t            state_q, state_d;
  logic [ACC_W-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  term_re, term_im, sum_re, sum_im;
  logic              sat_re, sat_im, accept;

  assign term_re = {{(ACC_W-PW){in_data[2*PW-1]}}, in_data[2*PW-1:PW]};
  assign term_im = {{(ACC_W-PW){in_data[PW-1]}}, in_data[PW-1:0]};

  cmplx_sat_add #(.W(ACC_W)) u_add_re (.a(acc_re_q), .b(term_re), .sum(sum_re), .sat(sat_re));
  cmplx_sat_add #(.W(ACC_W)) u_add_im (.a(acc_im_q), .b(term_im), .sum(sum_im), .sat(sat_im));

  assign in_ready  = (state_q != DONE) || out_ready;
  assign accept    = in_valid && in_ready;
  assign cnt_inc   = cnt_q + 1'b1;
  assign out_valid = (state_q == DONE);
  assign out_data  = {acc_re_q, acc_im_q};
  assign out_count = cnt_q;
  assign out_ovf   = ovf_q;

  // An accept outside ACC always opens a new frame, including the no-bubble restart from DONE
  always_comb begin
    state_d  = state_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (accept && state_q != ACC) begin
      acc_re_d = term_re;
      acc_im_d = term_im;
      cnt_d    = CNT_W'(1);
      ovf_d    = 1'b0;
      state_d  = (in_last || MAX_TERMS == 1) ? DONE : ACC;
    end else if (accept) begin
      acc_re_d = sum_re;
      acc_im_d = sum_im;
      cnt_d    = cnt_inc;
      ovf_d    = ovf_q | sat_re | sat_im;
      state_d  = (in_last || cnt_inc == MAX_CNT) ? DONE : ACC;
    end else if (state_q == DONE && out_ready) begin
      state_d  = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_re_q <= '0;
      acc_im_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
